// File: rtl/align_read_scheduler.sv
// Round-robin AR arbiter sharing one AXI read port between vector clusters, with an
// in-order tracker FIFO that routes R beats back and drives the alignment shift enables.
module align_read_scheduler #(
  parameter int unsigned NrRequesters = 4,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 512,
  parameter int unsigned NumTrackers  = 8,
  parameter int unsigned LenWidth     = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NrRequesters-1:0]                req_ar_valid_i,
  output logic [NrRequesters-1:0]                req_ar_ready_o,
  input  logic [NrRequesters*AxiAddrWidth-1:0]   req_ar_addr_i,
  input  logic [NrRequesters*LenWidth-1:0]       req_ar_len_i,
  output logic                                   ar_valid_o,
  input  logic                                   ar_ready_i,
  output logic [AxiAddrWidth-1:0]                ar_addr_o,
  output logic [LenWidth-1:0]                    ar_len_o,
  input  logic                                   r_valid_i,
  output logic                                   r_ready_o,
  input  logic                                   r_last_i,
  output logic [NrRequesters-1:0]                req_r_valid_o,
  input  logic [NrRequesters-1:0]                req_r_ready_i,
  output logic                                   req_r_last_o,
  output logic [$clog2(AxiDataWidth/8)-1:0]      shift_en_o,
  output logic [$clog2(NumTrackers):0]           outstanding_o,
  output logic                                   len_err_o
);

  localparam int unsigned NumStages = $clog2(AxiDataWidth/8);
  localparam int unsigned IdxWidth  = $clog2(NrRequesters);
  localparam int unsigned PtrWidth  = $clog2(NumTrackers);
  localparam int unsigned CntWidth  = PtrWidth + 1;

  logic [AxiAddrWidth-1:0] req_addr [NrRequesters];
  logic [LenWidth-1:0]     req_len  [NrRequesters];

  logic [IdxWidth-1:0]  rr_q, grant_q, arb_grant, cand, grant;
  logic                 arb_found, lock_q;
  logic [PtrWidth-1:0]  wptr_q, rptr_q;
  logic [CntWidth-1:0]  count_q;
  logic [LenWidth-1:0]  beat_q;
  logic                 full, empty, ar_push, r_fire, r_pop, last_beat;

  logic [IdxWidth-1:0]  trk_idx [NumTrackers];
  logic [LenWidth-1:0]  trk_len [NumTrackers];
  logic [NumStages-1:0] trk_off [NumTrackers];

  logic [IdxWidth-1:0]  head_idx;
  logic [LenWidth-1:0]  head_len;
  logic [NumStages-1:0] head_off;

  for (genvar i = 0; i < NrRequesters; i++) begin : gen_unpack
    assign req_addr[i] = req_ar_addr_i[i*AxiAddrWidth +: AxiAddrWidth];
    assign req_len[i]  = req_ar_len_i[i*LenWidth +: LenWidth];
  end

  assign full  = (count_q == CntWidth'(NumTrackers));
  assign empty = (count_q == '0);

  // First valid requester at or after the round-robin pointer, wrapping around.
  always_comb begin
    arb_grant = rr_q;
    arb_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NrRequesters; k++) begin
      cand = rr_q + IdxWidth'(k);
      if (!arb_found && req_ar_valid_i[cand]) begin
        arb_grant = cand;
        arb_found = 1'b1;
      end
    end
  end

  // A presented-but-unaccepted AR stays pinned to its requester until the handshake.
  assign grant      = lock_q ? grant_q : arb_grant;
  assign ar_valid_o = lock_q | ((|req_ar_valid_i) & ~full);
  assign ar_addr_o  = req_addr[grant];
  assign ar_len_o   = req_len[grant];
  assign ar_push    = ar_valid_o & ar_ready_i;

  always_comb begin
    req_ar_ready_o        = '0;
    req_ar_ready_o[grant] = ar_ready_i & ~full;
  end

  assign head_idx  = trk_idx[rptr_q];
  assign head_len  = trk_len[rptr_q];
  assign head_off  = trk_off[rptr_q];
  assign last_beat = (beat_q == head_len);

  assign shift_en_o    = empty ? '0 : head_off;
  assign req_r_valid_o = empty ? '0 : (NrRequesters'(r_valid_i) << head_idx);
  assign r_ready_o     = ~empty & req_r_ready_i[head_idx];
  assign req_r_last_o  = ~empty & last_beat;
  assign r_fire        = r_valid_i & r_ready_o;
  assign r_pop         = r_fire & last_beat;
  assign len_err_o     = r_fire & (r_last_i != last_beat);
  assign outstanding_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q  <= 1'b0;
      grant_q <= '0;
      rr_q    <= '0;
      wptr_q  <= '0;
    end else begin
      if (ar_valid_o && !ar_ready_i) begin
        lock_q  <= 1'b1;
        grant_q <= grant;
      end else if (ar_push) begin
        lock_q <= 1'b0;
      end
      if (ar_push) begin
        wptr_q <= wptr_q + PtrWidth'(1);
        rr_q   <= grant + IdxWidth'(1);
      end
    end
  end

  // Entry storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (ar_push) begin
      trk_idx[wptr_q] <= grant;
      trk_len[wptr_q] <= ar_len_o;
      trk_off[wptr_q] <= ar_addr_o[NumStages-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      beat_q  <= '0;
      count_q <= '0;
    end else begin
      if (r_fire) begin
        if (last_beat) begin
          rptr_q <= rptr_q + PtrWidth'(1);
          beat_q <= '0;
        end else begin
          beat_q <= beat_q + LenWidth'(1);
        end
      end
      case ({ar_push, r_pop})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_align_read_scheduler.sv
// Scoreboard bench for align_read_scheduler: expected bursts are queued at AR handshake
// and checked beat by beat as the R data is routed back.
module tb_align_read_scheduler;

  localparam int NR = 4;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int NT = 8;
  localparam int LW = 8;
  localparam int NS = 6;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [NR-1:0]    req_ar_valid_i, req_ar_ready_o;
  logic [NR*AW-1:0] req_ar_addr_i;
  logic [NR*LW-1:0] req_ar_len_i;
  logic             ar_valid_o, ar_ready_i;
  logic [AW-1:0]    ar_addr_o;
  logic [LW-1:0]    ar_len_o;
  logic             r_valid_i, r_ready_o, r_last_i;
  logic [NR-1:0]    req_r_valid_o, req_r_ready_i;
  logic             req_r_last_o;
  logic [NS-1:0]    shift_en_o;
  logic [3:0]       outstanding_o;
  logic             len_err_o;

  typedef struct { int idx; int len; int off; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  align_read_scheduler #(
    .NrRequesters(NR), .AxiAddrWidth(AW), .AxiDataWidth(DW), .NumTrackers(NT), .LenWidth(LW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_ar_valid_i(req_ar_valid_i), .req_ar_ready_o(req_ar_ready_o),
    .req_ar_addr_i(req_ar_addr_i), .req_ar_len_i(req_ar_len_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_last_i(r_last_i),
    .req_r_valid_o(req_r_valid_o), .req_r_ready_i(req_r_ready_i), .req_r_last_o(req_r_last_o),
    .shift_en_o(shift_en_o), .outstanding_o(outstanding_o), .len_err_o(len_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic clear_inputs();
    req_ar_valid_i = '0; req_ar_addr_i = '0; req_ar_len_i = '0; ar_ready_i = 1'b0;
    r_valid_i = 1'b0; r_last_i = 1'b0; req_r_ready_i = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_ni = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    step();
  endtask

  // Drains every queued burst, checking routing, shift enables and the computed last.
  task automatic test_r_routing();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      for (int b = 0; b <= e.len; b++) begin
        step();
        r_valid_i = 1'b1; r_last_i = (b == e.len); req_r_ready_i = '1;
        @(negedge clk_i);
        checks++; if (req_r_valid_o !== NR'(1 << e.idx)) begin failures++; $display("[TB] FAIL route_valid beat=%0d got=%b exp=%b", b, req_r_valid_o, NR'(1 << e.idx)); end
        checks++; if (shift_en_o !== NS'(e.off)) begin failures++; $display("[TB] FAIL route_shift got=%b exp=%b", shift_en_o, NS'(e.off)); end
        checks++; if (req_r_last_o !== (b == e.len)) begin failures++; $display("[TB] FAIL route_last beat=%0d got=%b exp=%b", b, req_r_last_o, (b == e.len)); end
        checks++; if (r_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL route_ready got=%b exp=1", r_ready_o); end
      end
    end
    step();
    r_valid_i = 1'b0; r_last_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    @(negedge clk_i);
    checks++; if ({ar_valid_o, r_ready_o, req_r_last_o, len_err_o} !== 4'b0) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=0000", {ar_valid_o, r_ready_o, req_r_last_o, len_err_o}); end
    checks++; if (req_ar_ready_o !== '0 || req_r_valid_o !== '0) begin failures++; $display("[TB] FAIL reset_vectors got=%b/%b exp=0/0", req_ar_ready_o, req_r_valid_o); end
    checks++; if (shift_en_o !== '0 || outstanding_o !== '0) begin failures++; $display("[TB] FAIL reset_counts got=%0d/%0d exp=0/0", shift_en_o, outstanding_o); end
    @(negedge clk_i) rst_ni = 1'b1;
    step();
  endtask

  task automatic test_single();
    apply_reset();
    req_ar_valid_i = 4'b0100; req_ar_addr_i[2*AW +: AW] = 64'h1005; req_ar_len_i[2*LW +: LW] = 8'd3; ar_ready_i = 1'b1;
    @(negedge clk_i);
    checks++; if (ar_valid_o !== 1'b1 || ar_addr_o !== 64'h1005) begin failures++; $display("[TB] FAIL single_ar got=%b/%h exp=1/1005", ar_valid_o, ar_addr_o); end
    checks++; if (ar_len_o !== 8'd3 || req_ar_ready_o !== 4'b0100) begin failures++; $display("[TB] FAIL single_len_ready got=%0d/%b exp=3/0100", ar_len_o, req_ar_ready_o); end
    sb.push_back('{idx: 2, len: 3, off: 5});
    step();
    req_ar_valid_i = '0; ar_ready_i = 1'b0;
    @(negedge clk_i);
    checks++; if (outstanding_o !== 4'd1) begin failures++; $display("[TB] FAIL single_outstanding got=%0d exp=1", outstanding_o); end
    test_r_routing();
    @(negedge clk_i);
    checks++; if (outstanding_o !== 4'd0) begin failures++; $display("[TB] FAIL single_drained got=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_round_robin();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      req_ar_addr_i[i*AW +: AW] = AW'(64'h100 * (i + 1) + i);
      req_ar_len_i[i*LW +: LW]  = LW'(i);
    end
    req_ar_valid_i = '1; ar_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      checks++; if (ar_addr_o !== AW'(64'h100 * (exp_g[k] + 1) + exp_g[k]) || req_ar_ready_o !== NR'(1 << exp_g[k])) begin
        failures++; $display("[TB] FAIL rr_grant k=%0d got=%h/%b exp_req=%0d", k, ar_addr_o, req_ar_ready_o, exp_g[k]); end
      sb.push_back('{idx: exp_g[k], len: exp_g[k], off: exp_g[k]});
      step();
    end
    req_ar_valid_i = '0; ar_ready_i = 1'b0;
    @(negedge clk_i);
    checks++; if (outstanding_o !== 4'd5) begin failures++; $display("[TB] FAIL rr_outstanding got=%0d exp=5", outstanding_o); end
    test_r_routing();
  endtask

  task automatic test_lock();
    apply_reset();
    req_ar_addr_i[0 +: AW] = 64'hA000; req_ar_len_i[0 +: LW] = 8'd1;
    req_ar_addr_i[AW +: AW] = 64'hB000; req_ar_len_i[LW +: LW] = 8'd0;
    req_ar_valid_i = 4'b0011; ar_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      checks++; if (ar_valid_o !== 1'b1 || ar_addr_o !== 64'hA000) begin failures++; $display("[TB] FAIL lock_wait k=%0d got=%b/%h exp=1/a000", k, ar_valid_o, ar_addr_o); end
      step();
    end
    req_ar_valid_i = 4'b0010;
    @(negedge clk_i);
    checks++; if (ar_valid_o !== 1'b1 || ar_addr_o !== 64'hA000 || req_ar_ready_o !== 4'b0000) begin
      failures++; $display("[TB] FAIL lock_hold got=%b/%h/%b exp=1/a000/0000", ar_valid_o, ar_addr_o, req_ar_ready_o); end
    step();
    ar_ready_i = 1'b1;
    @(negedge clk_i);
    checks++; if (ar_addr_o !== 64'hA000 || req_ar_ready_o !== 4'b0001) begin failures++; $display("[TB] FAIL lock_accept got=%h/%b exp=a000/0001", ar_addr_o, req_ar_ready_o); end
    sb.push_back('{idx: 0, len: 1, off: 0});
    step();
    @(negedge clk_i);
    checks++; if (ar_addr_o !== 64'hB000 || req_ar_ready_o !== 4'b0010) begin failures++; $display("[TB] FAIL lock_release got=%h/%b exp=b000/0010", ar_addr_o, req_ar_ready_o); end
    sb.push_back('{idx: 1, len: 0, off: 0});
    step();
    req_ar_valid_i = '0; ar_ready_i = 1'b0;
    test_r_routing();
  endtask

  task automatic test_full();
    apply_reset();
    req_ar_addr_i[0 +: AW] = 64'h2003; req_ar_len_i[0 +: LW] = 8'd0;
    req_ar_valid_i = 4'b0001; ar_ready_i = 1'b1;
    for (int k = 0; k < NT; k++) begin
      sb.push_back('{idx: 0, len: 0, off: 3});
      step();
    end
    @(negedge clk_i);
    checks++; if (ar_valid_o !== 1'b0 || req_ar_ready_o !== 4'b0000) begin failures++; $display("[TB] FAIL full_block got=%b/%b exp=0/0000", ar_valid_o, req_ar_ready_o); end
    checks++; if (outstanding_o !== 4'd8) begin failures++; $display("[TB] FAIL full_count got=%0d exp=8", outstanding_o); end
    step();
    r_valid_i = 1'b1; r_last_i = 1'b1; req_r_ready_i = '1;
    @(negedge clk_i);
    checks++; if (r_ready_o !== 1'b1 || req_r_valid_o !== 4'b0001 || ar_valid_o !== 1'b0) begin
      failures++; $display("[TB] FAIL full_pop got=%b/%b/%b exp=1/0001/0", r_ready_o, req_r_valid_o, ar_valid_o); end
    void'(sb.pop_front());
    step();
    r_valid_i = 1'b0; r_last_i = 1'b0;
    @(negedge clk_i);
    checks++; if (ar_valid_o !== 1'b1 || req_ar_ready_o !== 4'b0001) begin failures++; $display("[TB] FAIL full_reaccept got=%b/%b exp=1/0001", ar_valid_o, req_ar_ready_o); end
    sb.push_back('{idx: 0, len: 0, off: 3});
    step();
    req_ar_valid_i = '0; ar_ready_i = 1'b0;
    @(negedge clk_i);
    checks++; if (outstanding_o !== 4'd8) begin failures++; $display("[TB] FAIL full_refill got=%0d exp=8", outstanding_o); end
    test_r_routing();
    @(negedge clk_i);
    checks++; if (outstanding_o !== 4'd0) begin failures++; $display("[TB] FAIL full_drained got=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_backpressure_mismatch();
    apply_reset();
    req_ar_addr_i[AW +: AW] = 64'h3007; req_ar_len_i[LW +: LW] = 8'd3;
    req_ar_valid_i = 4'b0010; ar_ready_i = 1'b1;
    step();
    req_ar_valid_i = '0; ar_ready_i = 1'b0;
    r_valid_i = 1'b1; r_last_i = 1'b0; req_r_ready_i = 4'b1101;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      checks++; if (r_ready_o !== 1'b0 || req_r_valid_o !== 4'b0010 || req_r_last_o !== 1'b0) begin
        failures++; $display("[TB] FAIL bp_stall k=%0d got=%b/%b/%b exp=0/0010/0", k, r_ready_o, req_r_valid_o, req_r_last_o); end
      step();
    end
    req_r_ready_i = '1;
    for (int b = 0; b < 4; b++) begin
      r_last_i = (b == 1) || (b == 3);
      @(negedge clk_i);
      checks++; if (req_r_last_o !== (b == 3) || len_err_o !== (b == 1) || r_ready_o !== 1'b1) begin
        failures++; $display("[TB] FAIL bp_beat b=%0d got last=%b err=%b rdy=%b exp last=%b err=%b rdy=1", b, req_r_last_o, len_err_o, r_ready_o, (b == 3), (b == 1)); end
      step();
    end
    r_valid_i = 1'b0; r_last_i = 1'b0;
    @(negedge clk_i);
    checks++; if (outstanding_o !== 4'd0 || len_err_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_done got=%0d/%b exp=0/0", outstanding_o, len_err_o); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req_ar_addr_i[3*AW +: AW] = 64'h4002; req_ar_len_i[3*LW +: LW] = 8'd3;
    req_ar_valid_i = 4'b1000; ar_ready_i = 1'b1;
    step();
    req_ar_valid_i = '0; ar_ready_i = 1'b0;
    r_valid_i = 1'b1; r_last_i = 1'b0; req_r_ready_i = '1;
    step();
    step();
    rst_ni = 1'b0;
    @(negedge clk_i);
    checks++; if (req_r_valid_o !== '0 || r_ready_o !== 1'b0 || req_r_last_o !== 1'b0 || len_err_o !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_reset_r got=%b/%b/%b/%b exp=0", req_r_valid_o, r_ready_o, req_r_last_o, len_err_o); end
    checks++; if (shift_en_o !== '0 || outstanding_o !== '0 || ar_valid_o !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_reset_state got=%b/%0d/%b exp=0", shift_en_o, outstanding_o, ar_valid_o); end
    rst_ni = 1'b1;
    step();
    @(negedge clk_i);
    checks++; if (req_r_valid_o !== '0 || r_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_noroute got=%b/%b exp=0/0", req_r_valid_o, r_ready_o); end
    step();
    r_valid_i = 1'b0;
    req_ar_addr_i[3*AW +: AW] = 64'h4001; req_ar_len_i[3*LW +: LW] = 8'd1;
    req_ar_valid_i = 4'b1000; ar_ready_i = 1'b1;
    sb.push_back('{idx: 3, len: 1, off: 1});
    step();
    req_ar_valid_i = '0; ar_ready_i = 1'b0;
    test_r_routing();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_full();
    test_backpressure_mismatch();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog got=timeout exp=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/align_read_scheduler.md
Name: align_read_scheduler

Overview:
- Shares one AXI read port, and the staged byte-alignment datapath behind it, between NrRequesters vector clusters.
- Arbitrates AR requests round-robin and records each accepted burst in an in-order tracker FIFO.
- Routes returning R beats to the originating requester.
- Drives the per-stage shift enables for the beat currently leaving memory.

Parameters:
- NrRequesters, 4, number of requesting clusters (power of 2, at least 2).
- AxiAddrWidth, 64, AR address width.
- AxiDataWidth, 512, R data width; NumStages = $clog2(AxiDataWidth/8).
- NumTrackers, 8, tracker FIFO depth (power of 2).
- LenWidth, 8, AXI burst length field width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_ar_valid_i  in  NrRequesters  per-requester AR valid.
- req_ar_ready_o  out  NrRequesters  per-requester AR ready.
- req_ar_addr_i  in  NrRequesters*AxiAddrWidth  per-requester address.
- req_ar_len_i  in  NrRequesters*LenWidth  per-requester burst length minus 1.
- ar_valid_o  out  1  AR valid to memory.
- ar_ready_i  in  1  AR ready from memory.
- ar_addr_o  out  AxiAddrWidth  granted address.
- ar_len_o  out  LenWidth  granted length.
- r_valid_i  in  1  R valid from memory.
- r_ready_o  out  1  R ready to memory.
- r_last_i  in  1  R last from memory.
- req_r_valid_o  out  NrRequesters  one-hot routed R valid.
- req_r_ready_i  in  NrRequesters  per-requester R ready.
- req_r_last_o  out  1  scheduler-computed last beat.
- shift_en_o  out  NumStages  stage s shifts by 2^s bytes when bit s is set.
- outstanding_o  out  $clog2(NumTrackers)+1  tracker occupancy.
- len_err_o  out  1  one-cycle pulse on a last-beat mismatch.

Behaviour:
- Reset values:
  - State: all counters/pointers 0, rr_q=0, lock_q=0.
  - Outputs: ar_valid_o=0, r_ready_o=0, req_r_valid_o=0, req_ar_ready_o=0, shift_en_o=0, outstanding_o=0, len_err_o=0.
  - Reset mid-burst drops all tracker entries; no beat is routed afterwards.
- full = (count==NumTrackers); empty = (count==0).
- Arbitration, with no lock held:
  - grant = first index i, scanning rr_q, rr_q+1, ... with wrap, whose req_ar_valid_i[i]=1.
  - ar_valid_o = (|req_ar_valid_i) & !full.
  - ar_addr_o/ar_len_o are muxed from the grant combinationally (0 latency).
- Lock (AXI stability):
  - If ar_valid_o=1 and ar_ready_i=0, set lock_q=1 and register grant_q.
  - While locked, grant=grant_q and ar_valid_o=1. This holds even if full, which cannot become newly true because no push occurs while locked.
  - The lock clears on handshake.
- req_ar_ready_o[grant] = ar_ready_i & !full; all other bits 0.
- Push: on ar_valid_o & ar_ready_i, write {idx=grant, len=ar_len_o, off=ar_addr_o[NumStages-1:0]} at wptr; wptr wraps at NumTrackers-1. Set rr_q = grant+1 mod NrRequesters.
- Head entry = tracker[rptr].
  - shift_en_o = empty ? 0 : head.off.
  - req_r_valid_o = empty ? 0 : (r_valid_i << head.idx).
  - r_ready_o = !empty & req_r_ready_i[head.idx].
  - req_r_last_o = !empty & (beat_q==head.len).
- Beat handshake (r_valid_i & r_ready_o):
  - beat_q increments. If beat_q==head.len, pop: rptr advances with wrap, beat_q=0.
  - len_err_o = 1 for that cycle if r_last_i != (beat_q==head.len); routing follows the computed last regardless.
- Simultaneous push and pop: count unchanged. Push while full is impossible (ready gated). Pop while empty is impossible (r_ready_o=0).
- Memory R beats arriving while empty are not accepted (back-pressured).
- outstanding_o = count_q, registered.
- No combinational path from r_* to ar_*.

Test Plan:
- Single request: requester 2, addr 0x1005, len 3, ar_ready_i=1 → AR handshake in cycle 0; 4 beats routed with req_r_valid_o=4'b0100, shift_en_o=6'b000101, req_r_last_o on beat 4; outstanding_o goes 1→0.
- Round-robin: all 4 requesters valid continuously with ar_ready_i=1 → grants 0,1,2,3,0 on consecutive cycles; R beats return in the same order to the matching requester.
- Lock: requesters 0 and 1 valid, ar_ready_i=0 for 3 cycles, requester 0 then drops its valid → ar_addr_o stays on requester 0 and ar_valid_o stays 1 until ar_ready_i=1.
- Full: 8 accepted bursts with no R beats → ar_valid_o=0 and req_ar_ready_o=0. One pop in cycle N → a new AR is accepted in cycle N+1 and outstanding_o returns to 8.
- Back-pressure and mismatch:
  - req_r_ready_i[head]=0 → r_ready_o=0 and beat_q is held.
  - r_last_i=1 on beat 2 of a len=3 burst → len_err_o pulses for 1 cycle; the burst still completes after 4 beats.
- Reset mid-burst: assert rst_ni=0 after 2 of 4 beats → all outputs 0, outstanding_o=0; the next request starts at beat_q=0.
